// File: rtl/rect_fill_if.sv
// Command and shared pixel-bus bundle for rect_fill. The four vga_* nets are
// tristate so several drawers can share one VGA adapter.
interface rect_fill_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 24
);
  logic               start;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [X_W:0]       w;
  logic [Y_W:0]       h;
  logic [COLOR_W-1:0] color;
  logic               draw_ready;
  logic               busy;
  logic               done;

  tri   [X_W-1:0]     vga_x_out_bus;
  tri   [Y_W-1:0]     vga_y_out_bus;
  tri   [COLOR_W-1:0] vga_RGB_out_bus;
  tri                 vga_draw_enable_bus;

  // master: the fill engine; slave: the command source and VGA sink
  modport master (
    input  start, x0, y0, w, h, color, draw_ready,
    output busy, done,
    output vga_x_out_bus, vga_y_out_bus, vga_RGB_out_bus, vga_draw_enable_bus
  );

  modport slave (
    output start, x0, y0, w, h, color, draw_ready,
    input  busy, done,
    input  vga_x_out_bus, vga_y_out_bus, vga_RGB_out_bus, vga_draw_enable_bus
  );
endinterface

// File: rtl/rect_fill.sv
// Rectangle-fill engine emitting one pixel per handshake in raster order onto a
// shared tristate VGA bus. Optional screen clipping: define RECT_FILL_CLIP_EN.
module rect_fill #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 24,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  rect_fill_if.master bus
);

`ifdef RECT_FILL_CLIP_EN
  localparam logic LP_CLIP_EN = 1'b1;
`else
  localparam logic LP_CLIP_EN = 1'b0;
`endif

  localparam logic [X_W:0] LP_SCREEN_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LP_SCREEN_H = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] LP_ONE_X    = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0] LP_ONE_Y    = {{Y_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [X_W-1:0]     r_x0, w_x0_nxt;
  logic [Y_W-1:0]     r_y0, w_y0_nxt;
  logic [X_W:0]       r_w,  w_w_nxt;
  logic [Y_W:0]       r_h,  w_h_nxt;
  logic [COLOR_W-1:0] r_color, w_color_nxt;
  logic [X_W-1:0]     r_cx, w_cx_nxt;
  logic [Y_W-1:0]     r_cy, w_cy_nxt;

  logic [X_W-1:0]     r_px;
  logic [Y_W-1:0]     r_py;
  logic               r_en;
  logic               r_drive;
  logic               r_busy;
  logic               r_done;

  logic               w_advance;
  logic               w_last_col;
  logic               w_last_row;
  logic [X_W:0]       w_sx_nxt;
  logic [Y_W:0]       w_sy_nxt;
  logic               w_vis_nxt;

  // A clipped pixel (r_en low in DRAW) advances without waiting for the sink.
  assign w_advance  = (r_state == S_DRAW) && (bus.draw_ready || !r_en);
  assign w_last_col = ({1'b0, r_cx} == (r_w - LP_ONE_X));
  assign w_last_row = ({1'b0, r_cy} == (r_h - LP_ONE_Y));

  // Unwrapped coordinate sums: low bits are the wrapped pixel, MSB feeds clipping.
  assign w_sx_nxt  = {1'b0, w_x0_nxt} + {1'b0, w_cx_nxt};
  assign w_sy_nxt  = {1'b0, w_y0_nxt} + {1'b0, w_cy_nxt};
  assign w_vis_nxt = !LP_CLIP_EN || ((w_sx_nxt < LP_SCREEN_W) && (w_sy_nxt < LP_SCREEN_H));

  // Next-state, operand latch and raster counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x0_nxt    = r_x0;
    w_y0_nxt    = r_y0;
    w_w_nxt     = r_w;
    w_h_nxt     = r_h;
    w_color_nxt = r_color;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_x0_nxt    = bus.x0;
          w_y0_nxt    = bus.y0;
          w_w_nxt     = bus.w;
          w_h_nxt     = bus.h;
          w_color_nxt = bus.color;
          w_cx_nxt    = {X_W{1'b0}};
          w_cy_nxt    = {Y_W{1'b0}};
          if ((bus.w != {(X_W+1){1'b0}}) && (bus.h != {(Y_W+1){1'b0}})) begin
            w_state_nxt = S_DRAW;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAW: begin
        if (w_advance) begin
          if (w_last_col) begin
            w_cx_nxt = {X_W{1'b0}};
            if (w_last_row) begin
              w_state_nxt = S_DONE;
            end else begin
              w_cy_nxt = r_cy + {{(Y_W-1){1'b0}}, 1'b1};
            end
          end else begin
            w_cx_nxt = r_cx + {{(X_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = S_DRAW;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operands, counters and the registered pixel/status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_x0    <= {X_W{1'b0}};
      r_y0    <= {Y_W{1'b0}};
      r_w     <= {(X_W+1){1'b0}};
      r_h     <= {(Y_W+1){1'b0}};
      r_color <= {COLOR_W{1'b0}};
      r_cx    <= {X_W{1'b0}};
      r_cy    <= {Y_W{1'b0}};
      r_px    <= {X_W{1'b0}};
      r_py    <= {Y_W{1'b0}};
      r_en    <= 1'b0;
      r_drive <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x0    <= w_x0_nxt;
      r_y0    <= w_y0_nxt;
      r_w     <= w_w_nxt;
      r_h     <= w_h_nxt;
      r_color <= w_color_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_px    <= w_sx_nxt[X_W-1:0];
      r_py    <= w_sy_nxt[Y_W-1:0];
      r_en    <= (w_state_nxt == S_DRAW) && w_vis_nxt;
      r_drive <= (w_state_nxt == S_DRAW);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // The shared bus is only driven while drawing.
  assign bus.vga_x_out_bus       = r_drive ? r_px    : {X_W{1'bz}};
  assign bus.vga_y_out_bus       = r_drive ? r_py    : {Y_W{1'bz}};
  assign bus.vga_RGB_out_bus     = r_drive ? r_color : {COLOR_W{1'bz}};
  assign bus.vga_draw_enable_bus = r_drive ? r_en    : 1'bz;

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: table of fills plus a reset-mid-fill
// sequence; emitted pixels are scored against a queue of expected pixels.
module tb_rect_fill;
  localparam int X_W = 8;
  localparam int Y_W = 8;
  localparam int COLOR_W = 24;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
`ifdef RECT_FILL_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;

  rect_fill_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

  rect_fill #(
    .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [8:0]  h;
    logic [23:0] color;
    int          stall_at;
    int          stall_len;
    int          dup_at;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];

  logic bus_free;
  assign bus_free = (bus.vga_draw_enable_bus === 1'bz) &&
                    (bus.vga_x_out_bus === {X_W{1'bz}}) &&
                    (bus.vga_y_out_bus === {Y_W{1'bz}}) &&
                    (bus.vga_RGB_out_bus === {COLOR_W{1'bz}});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every transfer, checks holds during stalls.
  initial begin
    logic [39:0] cur;
    logic [39:0] prev;
    bit stalled;
    stalled = 1'b0;
    prev = 40'h0;
    forever begin
      @(negedge clk);
      if (resetn && bus.vga_draw_enable_bus === 1'b1) begin
        cur = {bus.vga_x_out_bus, bus.vga_y_out_bus, bus.vga_RGB_out_bus};
        if (stalled) chk("stall_hold", {24'h0, cur}, {24'h0, prev});
        if (bus.draw_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_pixel: got %0h expected none", cur);
          end else begin
            chk("pixel", {24'h0, cur}, {24'h0, exp_q.pop_front()});
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = cur;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic push_expected(input vec_t v);
    int sx;
    int sy;
    for (int cy = 0; cy < int'(v.h); cy++) begin
      for (int cx = 0; cx < int'(v.w); cx++) begin
        sx = int'(v.x0) + cx;
        sy = int'(v.y0) + cy;
        if (!CLIP || (sx < SCREEN_W && sy < SCREEN_H))
          exp_q.push_back({8'(sx), 8'(sy), v.color});
      end
    end
  endtask

  task automatic do_fill(input vec_t v);
    int lat;
    int lat_exp;
    lat_exp = (v.w == 9'd0 || v.h == 9'd0) ? 1 : int'(v.w) * int'(v.h) + 1 + v.stall_len;
    push_expected(v);
    chk("idle_bus_z", {63'h0, bus_free}, 64'h1);
    bus.x0 = v.x0; bus.y0 = v.y0; bus.w = v.w; bus.h = v.h; bus.color = v.color;
    bus.start = 1'b1;
    @(posedge clk); #1;
    // operands change after acceptance; the fill must not notice
    bus.start = 1'b0;
    bus.x0 = ~v.x0; bus.y0 = ~v.y0; bus.w = 9'd1; bus.h = 9'd1; bus.color = ~v.color;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 25000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == v.stall_at) bus.draw_ready = 1'b0;
      if (lat == v.stall_at + v.stall_len) bus.draw_ready = 1'b1;
      if (v.dup_at != 0 && lat == v.dup_at) begin
        bus.x0 = 8'd99; bus.y0 = 8'd98; bus.w = 9'd7; bus.h = 9'd7; bus.color = 24'h0F0F0F;
        bus.start = 1'b1;
      end
      if (v.dup_at != 0 && lat == v.dup_at + 1) bus.start = 1'b0;
    end
    bus.draw_ready = 1'b1;
    chk("done_latency", 64'(lat), 64'(lat_exp));
    chk("done_busy", {63'h0, bus.busy}, 64'h1);
    chk("done_bus_z", {63'h0, bus_free}, 64'h1);
    chk("pixels_left", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("done_one_cycle", {63'h0, bus.done}, 64'h0);
    chk("busy_after", {63'h0, bus.busy}, 64'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("no_extra_done", {63'h0, bus.done}, 64'h0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    int lat;
    vecs[0] = '{8'd10,  8'd20,  9'd3,   9'd2, 24'hFF0000, 0, 0, 0};
    vecs[1] = '{8'd10,  8'd20,  9'd3,   9'd2, 24'hFF0000, 2, 3, 0};
    vecs[2] = '{8'd0,   8'd5,   9'd0,   9'd5, 24'hABCDEF, 0, 0, 0};
    vecs[3] = '{8'd3,   8'd3,   9'd4,   9'd0, 24'h010203, 0, 0, 0};
    vecs[4] = '{8'd158, 8'd0,   9'd4,   9'd1, 24'h0000FF, 0, 0, 0};
    vecs[5] = '{8'd255, 8'd9,   9'd2,   9'd1, 24'h123456, 0, 0, 0};
    vecs[6] = '{8'd7,   8'd254, 9'd2,   9'd3, 24'h00FF00, 0, 0, 0};
    vecs[7] = '{8'd10,  8'd20,  9'd3,   9'd2, 24'hFF0000, 0, 0, 3};
    vecs[8] = '{8'd0,   8'd0,   9'd256, 9'd1, 24'h55AA55, 0, 0, 0};
    vecs[9] = '{8'd100, 8'd50,  9'd1,   9'd1, 24'hC0FFEE, 0, 0, 0};

    bus.start = 1'b0; bus.x0 = 8'd0; bus.y0 = 8'd0; bus.w = 9'd0; bus.h = 9'd0;
    bus.color = 24'd0; bus.draw_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_bus_z", {63'h0, bus_free}, 64'h1);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_fill(vecs[i]);

    // full-screen clear abandoned by reset after 100 pixels
    v = '{8'd0, 8'd0, 9'd160, 9'd120, 24'h000000, 0, 0, 0};
    push_expected(v);
    bus.x0 = v.x0; bus.y0 = v.y0; bus.w = v.w; bus.h = v.h; bus.color = v.color;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (lat < 101) begin
      @(posedge clk); #1;
      lat++;
    end
    resetn = 1'b0;
    #1;
    chk("midrst_bus_z", {63'h0, bus_free}, 64'h1);
    chk("midrst_busy", {63'h0, bus.busy}, 64'h0);
    chk("midrst_done", {63'h0, bus.done}, 64'h0);
    chk("midrst_pixels", 64'(int'(v.w) * int'(v.h) - exp_q.size()), 64'd100);
    exp_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {63'h0, bus.done}, 64'h0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_busy", {63'h0, bus.busy}, 64'h0);
    v = '{8'd5, 8'd5, 9'd1, 9'd1, 24'h5A5A5A, 0, 0, 0};
    do_fill(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rect_fill.md
# rect_fill

Parametrised rectangle-fill engine that replaces the full-screen clear sweep. On `start` it latches an origin, size and colour, then emits one pixel per accepted handshake in raster order (x fastest) onto the shared VGA pixel bus. It drives that bus only while drawing and releases it to high-Z otherwise, so several drawers can share the bus. It sits between the game FSM and the VGA adapter; a full-screen clear is a fill with origin (0,0) and size SCREEN_W×SCREEN_H.

## Interface
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 8: y coordinate width.
- `COLOR_W`, default 24: colour width.
- `SCREEN_W`, default 160: visible width; used only for clipping.
- `SCREEN_H`, default 120: visible height; used only for clipping.
- `clk` in 1: single clock; all logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request a fill; sampled only in IDLE.
- `x0` in X_W: rectangle origin x.
- `y0` in Y_W: rectangle origin y.
- `w` in X_W+1: width in pixels (0..2^X_W).
- `h` in Y_W+1: height in pixels (0..2^Y_W).
- `color` in COLOR_W: fill colour.
- `draw_ready` in 1: VGA side accepts the current pixel this cycle.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at completion.
- `vga_x_out_bus` out X_W: pixel x; tristate.
- `vga_y_out_bus` out Y_W: pixel y; tristate.
- `vga_RGB_out_bus` out COLOR_W: pixel colour; tristate.
- `vga_draw_enable_bus` out 1: pixel valid; tristate.

## Operation
- **States:** IDLE, DRAW, DONE.
- **IDLE → DRAW:** on an edge with `start`=1 and `w`≠0 and `h`≠0. `x0`, `y0`, `w`, `h` and `color` are latched; column counter `cx` and row counter `cy` clear to 0.
- **IDLE → DONE:** on an edge with `start`=1 and (`w`=0 or `h`=0). No pixel is emitted.
- **DRAW:**
  - The current pixel is x = x0+cx and y = y0+cy, each truncated to X_W/Y_W bits, so coordinates wrap modulo 2^width.
  - The pixel colour is the latched `color`.
  - A transfer occurs on an edge where `vga_draw_enable_bus`=1 and `draw_ready`=1.
  - On a transfer, `cx` increments. When `cx`=w−1 it wraps to 0 and `cy` increments.
  - The transfer with `cx`=w−1 and `cy`=h−1 moves the state to DONE.
- **DONE:** `done`=1 for exactly one cycle, then the state returns to IDLE.
- **Bus ownership:** the four bus outputs are driven only in DRAW and are high-Z in IDLE and DONE.
- **Unused start:** `start` in DRAW or DONE is ignored; there is no queueing.
- **Input changes:** changes on `x0`, `y0`, `w`, `h` or `color` after acceptance have no effect on the fill in progress.
- **Reset:** `resetn`=0 at any time, including mid-fill, forces IDLE immediately.
  - `busy`=0 and `done`=0.
  - All bus outputs go high-Z.
  - The counters and latched operands are zeroed.
  - The partial fill is abandoned and no `done` is produced.

## Timing
- **Acceptance:** `start` is accepted at edge E. The first pixel (x0,y0) is on the bus with `vga_draw_enable_bus`=1 in the cycle after E.
- **Throughput:** 1 pixel per cycle while `draw_ready`=1.
- **Backpressure:** while `draw_ready`=0, x, y, RGB and enable hold stable.
- **Total latency:** an unstalled, unclipped w×h fill spends w·h cycles in DRAW, then 1 cycle in DONE. `done` is high in cycle w·h+1 after E.
- **Zero size:** `done` is high in the cycle after E.
- **Next command:** a new `start` is accepted no earlier than the cycle after `done`.

## Configuration
- **`RECT_FILL_CLIP_EN` defined:**
  - Clipping uses the unwrapped sum x0+cx, which is X_W+1 bits wide, and likewise for y.
  - A pixel with that sum ≥ SCREEN_W, or the y sum ≥ SCREEN_H, is skipped. It occupies one DRAW cycle with `vga_draw_enable_bus`=0 and advances the counters without waiting for `draw_ready`.
  - Fully off-screen rectangles still take w·h DRAW cycles and end with `done`.
- **`RECT_FILL_CLIP_EN` undefined:**
  - There is no bounds check.
  - All w·h pixels are emitted with wrapped coordinates.

## Test plan
- **Small fill:** x0=10, y0=20, w=3, h=2, color=24'hFF0000, `draw_ready`=1 → six pixels in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all colour FF0000. `done` is high 7 cycles after acceptance, and the bus is high-Z before the first pixel and after the last.
- **Backpressure:** same fill with `draw_ready` low for 3 cycles on the 2nd pixel → (11,20) is held stable for those 3 cycles and never duplicated or dropped. `done` arrives 3 cycles later than the unstalled case.
- **Zero size:** w=0, h=5 → no enable pulse; `done`=1 one cycle after acceptance; `busy` high for 1 cycle only.
- **Clip and wrap:** x0=158, y0=0, w=4, h=1.
  - With `RECT_FILL_CLIP_EN`: only (158,0) and (159,0) are emitted, followed by two enable-low cycles, then `done`.
  - Without it: (158,0),(159,0),(160,0),(161,0) are emitted. Separately, x0=255, w=2 emits x=255 then x=0.
- **Reset mid-fill:** 160×120 clear, `resetn` pulsed low after 100 pixels → bus high-Z and `busy`=0 immediately with no `done`. A subsequent start of a 1×1 fill at (5,5) emits exactly (5,5).
- **Start while busy:** a second `start` with different operands during DRAW → ignored; the original fill completes unchanged with exactly one `done`.
